bus_hold_arbiter: RTL and testbench
===================================

BUS_HOLD_ARBITER -- requirements
Module: bus_hold_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of DMA requesters (2..8).
REQ-002 Parameter ROTATE, default 0: 0 = fixed priority with channel 0 highest; 1 = rotating priority.
REQ-003 Parameter WS_IO, default 1: wait states inserted on I/O commands (0..15).
REQ-004 Parameter WS_MEM, default 0: wait states inserted on memory commands (0..15).
REQ-005 Parameter TMO, default 255: maximum io_ch_rdy-low cycles before forced completion (1..1023).
REQ-006 clk  in  1  system clock; the only clock in the block.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 s_n  in  3  CPU status; 3'b111 means passive.
REQ-009 lock_n  in  1  CPU bus lock, active low.
REQ-010 hrq  in  NCH  DMA hold requests, active high, level.
REQ-011 eop  in  1  end of process for the granted channel, active high.
REQ-012 cmd_start  in  1  one-cycle pulse at the start of a bus command.
REQ-013 cmd_io  in  1  command type, qualified by cmd_start: 1 = I/O, 0 = memory.
REQ-014 io_ch_rdy  in  1  I/O channel ready; low extends the cycle.
REQ-015 holda  out  1  hold acknowledge.
REQ-016 aen  out  1  address enable; DMA owns the bus.
REQ-017 dack  out  NCH  one-hot DMA acknowledge.
REQ-018 rdy  out  1  ready to the bus master.
REQ-019 bus_err  out  1  one-cycle pulse on a ready timeout.

Function
REQ-020 All outputs SHALL be registered and change only on the rising edge of clk, except on reset assertion.
REQ-021 The FSM SHALL have states IDLE, SYNC, HOLD, GRANT and RELEASE.
REQ-022 IDLE -> SYNC when |hrq && s_n==3'b111 && lock_n==1; otherwise stay in IDLE.
REQ-023 SYNC -> HOLD when the same condition still holds; otherwise -> IDLE.
REQ-024 HOLD: register the winning channel from the current hrq and go to GRANT; if hrq==0, go to RELEASE.
REQ-025 GRANT: stay while hrq[sel]==1 && eop==0; on hrq[sel] falling or eop==1 (same cycle), go to RELEASE.
REQ-026 RELEASE: stay exactly one cycle, then go to IDLE; re-arbitration SHALL take at least 3 cycles after RELEASE.
REQ-027 Output decode: holda=1 in HOLD and GRANT; aen=1 in HOLD and GRANT; dack[sel]=1 only in GRANT; all are 0 in IDLE, SYNC and RELEASE.
REQ-028 ROTATE=0: the lowest-index active hrq SHALL win.
REQ-029 ROTATE=1: search order SHALL start at (last_served+1) mod NCH, wrapping from NCH-1 to 0; last_served updates on GRANT exit.
REQ-030 A change in hrq for non-selected channels SHALL have no effect during GRANT.
REQ-031 Wait counter: on cmd_start, load WS_IO if cmd_io==1, else WS_MEM; a cmd_start during an active count SHALL reload the counter.
REQ-032 rdy SHALL be 0 from the cycle after cmd_start while wcnt>0 or io_ch_rdy==0.
REQ-033 wcnt SHALL decrement by 1 per cycle and saturate at 0.
REQ-034 rdy SHALL return to 1 on the cycle after wcnt==0 && io_ch_rdy==1.
REQ-035 With WS=0 and io_ch_rdy==1 at cmd_start, rdy SHALL stay 1.
REQ-036 A timeout counter SHALL count cycles with rdy==0 && wcnt==0 && io_ch_rdy==0.
REQ-037 When the timeout count reaches TMO, the block SHALL force rdy=1, pulse bus_err for 1 cycle and clear the count.
REQ-038 The timeout count SHALL clear when io_ch_rdy rises.
REQ-039 The wait generator SHALL be independent of the arbitration FSM and SHALL operate in every state.

Reset
REQ-040 On reset=1, asynchronously: FSM=IDLE, holda=0, aen=0, dack=0, rdy=1, bus_err=0, wcnt=0, timeout count=0, last_served=NCH-1.
REQ-041 A reset during GRANT SHALL drop dack, aen and holda immediately, with no RELEASE cycle.
REQ-042 After reset deasserts, hrq SHALL be sampled on the first clk edge.

Verification
REQ-043 NCH=4, ROTATE=0, s_n=111, lock_n=1, hrq=4'b0110 -> holda=1 2 cycles later, then dack=4'b0010 the next cycle.
REQ-044 ROTATE=1, hrq=4'b1111 held, each grant ended by eop -> grant order 0,1,2,3,0, with a 4-cycle gap between GRANT exit and the next dack.
REQ-045 lock_n=0 with hrq=1 -> stays in IDLE, holda=0; after lock_n=1, holda=1 2 cycles later.
REQ-046 cmd_start with cmd_io=1, WS_IO=3, io_ch_rdy=1 -> rdy low for 3 cycles, high on the 4th after cmd_start.
REQ-047 TMO=8, io_ch_rdy held 0 after a memory command with WS_MEM=0 -> rdy=1 and bus_err pulse 9 cycles after cmd_start.
REQ-048 Reset asserted in GRANT -> holda, aen and dack all 0 before the next clk edge; rdy=1.

Source files
------------

// File: rtl/bus_hold_arbiter.sv
// DMA hold/acknowledge arbiter with a bus-cycle wait-state and ready-timeout generator.
// Arbitration FSM and wait generator share only clk/reset and run independently.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | bus with CPU, waiting for a request while CPU is passive/unlocked
// SYNC    | request seen once, confirming it is still valid
// HOLD    | holda/aen asserted, picking the winning channel
// GRANT   | dack asserted to the selected channel
// RELEASE | one dead cycle handing the bus back before re-arbitration
module bus_hold_arbiter #(
    parameter int NCH    = 4,
    parameter int ROTATE = 0,
    parameter int WS_IO  = 1,
    parameter int WS_MEM = 0,
    parameter int TMO    = 255
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     s_n,
    input  logic           lock_n,
    input  logic [NCH-1:0] hrq,
    input  logic           eop,
    input  logic           cmd_start,
    input  logic           cmd_io,
    input  logic           io_ch_rdy,
    output logic           holda,
    output logic           aen,
    output logic [NCH-1:0] dack,
    output logic           rdy,
    output logic           bus_err
);

    localparam int              SELW      = $clog2(NCH);
    localparam logic [SELW-1:0] LAST_INIT = SELW'(NCH - 1);
    localparam int              TW        = $clog2(TMO + 1);
    localparam logic [TW-1:0]   TMO_TC    = TW'(TMO - 1);
    localparam logic [3:0]      WS_IO_V   = 4'(WS_IO);
    localparam logic [3:0]      WS_MEM_V  = 4'(WS_MEM);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        HOLD    = 3'd2,
        GRANT   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] sel, sel_nxt;
    logic [SELW-1:0] last_served, last_nxt;
    logic [SELW-1:0] winner;
    logic [SELW-1:0] idx_s;
    logic            found;
    int              idx;
    logic            bus_free;
    logic            holda_nxt;
    logic [NCH-1:0]  dack_nxt;

    assign bus_free = (|hrq) && (s_n == 3'b111) && lock_n;

    // Search starts at channel 0 (fixed) or just past the last served channel (rotating).
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        idx_s  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ROTATE != 0) begin
                idx = (int'(last_served) + 1 + i) % NCH;
            end else begin
                idx = i;
            end
            idx_s = SELW'(idx);
            if (!found && hrq[idx_s]) begin
                winner = idx_s;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last_served;
        case (state)
            IDLE: begin
                if (bus_free) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                state_nxt = bus_free ? HOLD : IDLE;
            end
            HOLD: begin
                if (|hrq) begin
                    sel_nxt   = winner;
                    state_nxt = GRANT;
                end else begin
                    state_nxt = RELEASE;
                end
            end
            GRANT: begin
                if (!hrq[sel] || eop) begin
                    last_nxt  = sel;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        holda_nxt = (state_nxt == HOLD) || (state_nxt == GRANT);
        dack_nxt  = '0;
        if (state_nxt == GRANT) begin
            dack_nxt = NCH'(1) << sel_nxt;
        end
    end

    // Outputs are flopped from the next-state decode so they track the state register glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            last_served <= LAST_INIT;
            holda       <= 1'b0;
            aen         <= 1'b0;
            dack        <= '0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            last_served <= last_nxt;
            holda       <= holda_nxt;
            aen         <= holda_nxt;
            dack        <= dack_nxt;
        end
    end

    logic [3:0]    wcnt;
    logic [3:0]    wcnt_dec;
    logic [3:0]    ws_load;
    logic [TW-1:0] tcnt;
    logic          to_cond;
    logic          to_fire;

    assign wcnt_dec = (wcnt != 4'd0) ? (wcnt - 4'd1) : 4'd0;
    assign ws_load  = cmd_io ? WS_IO_V : WS_MEM_V;
    assign to_cond  = !rdy && (wcnt == 4'd0) && !io_ch_rdy;
    assign to_fire  = to_cond && (tcnt == TMO_TC) && !cmd_start;

    // rdy is low only inside a command; a new cmd_start always restarts the wait sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt    <= 4'd0;
            tcnt    <= '0;
            rdy     <= 1'b1;
            bus_err <= 1'b0;
        end else begin
            bus_err <= to_fire;
            if (cmd_start) begin
                wcnt <= ws_load;
                tcnt <= '0;
                rdy  <= (ws_load == 4'd0) && io_ch_rdy;
            end else begin
                wcnt <= wcnt_dec;
                tcnt <= (to_cond && !to_fire) ? (tcnt + TW'(1)) : '0;
                if (!rdy) begin
                    rdy <= to_fire || ((wcnt_dec == 4'd0) && io_ch_rdy);
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Bench for bus_hold_arbiter: fixed- and rotating-priority instances driven in parallel,
// directed scenarios followed by random traffic, checked against a behavioural model.
module tb_bus_hold_arbiter;

    localparam int N    = 4;
    localparam int WSI  = 3;
    localparam int WSM  = 0;
    localparam int TOUT = 8;

    logic       clk;
    logic       reset;
    logic [2:0] s_n;
    logic       lock_n;
    logic [3:0] hrq;
    logic       eop;
    logic       cmd_start;
    logic       cmd_io;
    logic       io_ch_rdy;

    logic       holda0, aen0, rdy0, bus_err0;
    logic [3:0] dack0;
    logic       holda1, aen1, rdy1, bus_err1;
    logic [3:0] dack1;

    int checks   = 0;
    int failures = 0;

    // model: arbitration progress per instance
    int arm[2];
    int owner[2];
    int rel[2];
    int last[2];
    // model: wait generator
    int wl, low, t, err;

    bus_hold_arbiter #(.NCH(N), .ROTATE(0), .WS_IO(WSI), .WS_MEM(WSM), .TMO(TOUT)) dut0 (
        .clk(clk), .reset(reset), .s_n(s_n), .lock_n(lock_n), .hrq(hrq), .eop(eop),
        .cmd_start(cmd_start), .cmd_io(cmd_io), .io_ch_rdy(io_ch_rdy),
        .holda(holda0), .aen(aen0), .dack(dack0), .rdy(rdy0), .bus_err(bus_err0)
    );

    bus_hold_arbiter #(.NCH(N), .ROTATE(1), .WS_IO(WSI), .WS_MEM(WSM), .TMO(TOUT)) dut1 (
        .clk(clk), .reset(reset), .s_n(s_n), .lock_n(lock_n), .hrq(hrq), .eop(eop),
        .cmd_start(cmd_start), .cmd_io(cmd_io), .io_ch_rdy(io_ch_rdy),
        .holda(holda1), .aen(aen1), .dack(dack1), .rdy(rdy1), .bus_err(bus_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int r, input int h);
        int c;
        for (int i = 0; i < N; i++) begin
            c = (r == 0) ? i : (last[r] + 1 + i) % N;
            if (((h >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_hold(input int r);
        return ((arm[r] == 2) || (owner[r] >= 0)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_dack(input int r);
        return (owner[r] >= 0) ? 32'(1 << owner[r]) : 32'd0;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 2; r++) begin
            arm[r] = 0; owner[r] = -1; rel[r] = 0; last[r] = N - 1;
        end
        wl = 0; low = 0; t = 0; err = 0;
    endtask

    task automatic m_step();
        int h;
        int elig;
        int cond;
        int fire;
        h    = int'(hrq);
        elig = (h != 0 && s_n == 3'b111 && lock_n == 1'b1) ? 1 : 0;
        for (int r = 0; r < 2; r++) begin
            if (rel[r] != 0) begin
                rel[r] = 0;
            end else if (owner[r] >= 0) begin
                if ((((h >> owner[r]) & 1) == 0) || eop) begin
                    last[r] = owner[r]; owner[r] = -1; rel[r] = 1;
                end
            end else if (arm[r] == 2) begin
                arm[r] = 0;
                if (h == 0) rel[r] = 1;
                else owner[r] = pick(r, h);
            end else if (elig != 0) begin
                arm[r]++;
            end else begin
                arm[r] = 0;
            end
        end
        if (cmd_start) begin
            wl  = cmd_io ? WSI : WSM;
            low = (wl == 0 && io_ch_rdy) ? 0 : 1;
            t   = 0;
            err = 0;
        end else begin
            cond = (low != 0 && wl == 0 && !io_ch_rdy) ? 1 : 0;
            fire = (cond != 0 && t == TOUT - 1) ? 1 : 0;
            t    = (cond != 0 && fire == 0) ? t + 1 : 0;
            if (wl > 0) wl--;
            if (low != 0 && (fire != 0 || (wl == 0 && io_ch_rdy))) low = 0;
            err = fire;
        end
    endtask

    task automatic check_all();
        chk("holda0", 32'(holda0), exp_hold(0));
        chk("aen0", 32'(aen0), exp_hold(0));
        chk("dack0", 32'(dack0), exp_dack(0));
        chk("holda1", 32'(holda1), exp_hold(1));
        chk("aen1", 32'(aen1), exp_hold(1));
        chk("dack1", 32'(dack1), exp_dack(1));
        chk("rdy0", 32'(rdy0), (low != 0) ? 32'd0 : 32'd1);
        chk("rdy1", 32'(rdy1), (low != 0) ? 32'd0 : 32'd1);
        chk("bus_err0", 32'(bus_err0), 32'(err));
        chk("bus_err1", 32'(bus_err1), 32'(err));
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_dack1(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (dack1 == 4'd0 && n < 12);
    endtask

    initial begin
        int n;
        reset = 1'b0; s_n = 3'b111; lock_n = 1'b1; hrq = 4'b0000; eop = 1'b0;
        cmd_start = 1'b0; cmd_io = 1'b0; io_ch_rdy = 1'b1;
        m_reset();
        #2;
        do_reset();
        chk("reset_rdy", 32'(rdy0), 32'd1);

        // fixed priority picks the lowest requester, two cycles to holda, one more to dack
        hrq = 4'b0110;
        tick(); chk("sync_holda", 32'(holda0), 32'd0);
        tick(); chk("hold_holda", 32'(holda0), 32'd1); chk("hold_dack", 32'(dack0), 32'd0);
        tick(); chk("grant_dack0", 32'(dack0), 32'h2); chk("grant_dack1", 32'(dack1), 32'h2);
        hrq = 4'b0000;
        tick(); chk("release_holda", 32'(holda0), 32'd0);
        tick();

        // bus locked: no hold until lock released
        lock_n = 1'b0; hrq = 4'b0001;
        repeat (3) begin
            tick(); chk("locked_holda", 32'(holda0), 32'd0);
        end
        lock_n = 1'b1;
        tick(); chk("unlock_sync", 32'(holda0), 32'd0);
        tick(); chk("unlock_holda", 32'(holda0), 32'd1);
        hrq = 4'b0000;
        tick(); chk("hold_norq_dack", 32'(dack0), 32'd0); chk("hold_norq_holda", 32'(holda0), 32'd0);
        tick();

        // I/O command with three wait states
        cmd_start = 1'b1; cmd_io = 1'b1; io_ch_rdy = 1'b1;
        tick(); cmd_start = 1'b0;
        chk("ws_rdy_1", 32'(rdy0), 32'd0);
        for (int i = 2; i <= 3; i++) begin
            tick(); chk("ws_rdy_low", 32'(rdy0), 32'd0);
        end
        tick(); chk("ws_rdy_4", 32'(rdy0), 32'd1);

        // zero-wait memory command keeps rdy high
        cmd_start = 1'b1; cmd_io = 1'b0;
        tick(); cmd_start = 1'b0;
        chk("ws0_rdy", 32'(rdy0), 32'd1);
        tick(); chk("ws0_rdy_2", 32'(rdy0), 32'd1);

        // ready timeout on a stalled memory command
        cmd_start = 1'b1; cmd_io = 1'b0; io_ch_rdy = 1'b0;
        tick(); cmd_start = 1'b0;
        chk("tmo_rdy_1", 32'(rdy0), 32'd0);
        for (int i = 2; i <= 8; i++) begin
            tick(); chk("tmo_rdy_low", 32'(rdy0), 32'd0); chk("tmo_err_low", 32'(bus_err0), 32'd0);
        end
        tick(); chk("tmo_rdy_9", 32'(rdy0), 32'd1); chk("tmo_err_9", 32'(bus_err0), 32'd1);
        tick(); chk("tmo_err_10", 32'(bus_err0), 32'd0); chk("tmo_rdy_10", 32'(rdy0), 32'd1);
        io_ch_rdy = 1'b1;
        tick();

        // rotating priority with all channels requesting, each grant ended by eop
        do_reset();
        hrq = 4'b1111;
        wait_dack1(n);
        chk("rot_first_latency", 32'(n), 32'd3);
        chk("rot_order_0", 32'(dack1), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            eop = 1'b1;
            tick();
            eop = 1'b0;
            wait_dack1(n);
            chk("rot_gap", 32'(n), 32'd4);
            chk("rot_order", 32'(dack1), 32'(1 << (k % N)));
        end

        // reset in GRANT drops everything before the next edge
        #2;
        reset = 1'b1;
        #1;
        chk("rst_holda", 32'(holda1), 32'd0);
        chk("rst_aen", 32'(aen1), 32'd0);
        chk("rst_dack", 32'(dack1), 32'd0);
        chk("rst_dack0", 32'(dack0), 32'd0);
        chk("rst_rdy", 32'(rdy1), 32'd1);
        do_reset();

        // random traffic
        hrq = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) hrq = hrq ^ (4'b0001 << b);
            end
            eop       = ($urandom_range(0, 9) == 0);
            s_n       = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            lock_n    = ($urandom_range(0, 9) != 0);
            cmd_start = ($urandom_range(0, 11) == 0);
            cmd_io    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) io_ch_rdy = ~io_ch_rdy;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
